// File: rtl/onehot_span_enc.sv
// One-hot to index encoder with span computation: two-stage valid/ready pipeline
// that flags malformed left/right pairs and tracks delivered-word statistics.
module onehot_span_enc #(
    parameter int WIDTH   = 12,
    parameter int CNT_W   = 16,
    localparam int IDX_W  = $clog2(WIDTH),
    localparam int SPAN_W = $clog2(WIDTH + 1)
) (
    input  logic              clk_i,
    input  logic              arst_ni,
    input  logic              clr_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [WIDTH-1:0]  left_oh_i,
    input  logic [WIDTH-1:0]  right_oh_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [IDX_W-1:0]  left_idx_o,
    output logic [IDX_W-1:0]  right_idx_o,
    output logic [SPAN_W-1:0] span_o,
    output logic              empty_o,
    output logic              err_o,
    output logic [SPAN_W-1:0] max_span_o,
    output logic [CNT_W-1:0]  word_cnt_o
);

    logic [IDX_W-1:0]  w_lterm [WIDTH];
    logic [IDX_W-1:0]  w_rterm [WIDTH];
    logic [IDX_W-1:0]  w_lidx;
    logic [IDX_W-1:0]  w_ridx;
    logic              w_lmulti;
    logic              w_rmulti;
    logic              w_adv1;
    logic              w_adv2;
    logic              w_in_hs;
    logic              w_out_hs;
    logic              w_err;
    logic              w_empty;
    logic [SPAN_W-1:0] w_span;

    logic              r_rdy_en;
    logic              r_s1_v;
    logic [IDX_W-1:0]  r_s1_lidx;
    logic [IDX_W-1:0]  r_s1_ridx;
    logic              r_s1_lzero;
    logic              r_s1_rzero;
    logic              r_s1_lmulti;
    logic              r_s1_rmulti;

    logic              r_s2_v;
    logic [IDX_W-1:0]  r_s2_lidx;
    logic [IDX_W-1:0]  r_s2_ridx;
    logic [SPAN_W-1:0] r_s2_span;
    logic              r_s2_empty;
    logic              r_s2_err;

    logic [SPAN_W-1:0] r_max_span;
    logic [CNT_W-1:0]  r_word_cnt;

    // Each set bit contributes its own position; OR-ing gives the index of a one-hot word.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_term
            assign w_lterm[gi] = left_oh_i[gi]  ? IDX_W'(gi) : '0;
            assign w_rterm[gi] = right_oh_i[gi] ? IDX_W'(gi) : '0;
        end
    endgenerate

    always_comb begin
        w_lidx = '0;
        w_ridx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_lidx = w_lidx | w_lterm[i];
            w_ridx = w_ridx | w_rterm[i];
        end
    end

    assign w_lmulti = |(left_oh_i  & (left_oh_i  - WIDTH'(1)));
    assign w_rmulti = |(right_oh_i & (right_oh_i - WIDTH'(1)));

    assign w_adv2   = !r_s2_v || ready_i;
    assign w_adv1   = !r_s1_v || w_adv2;
    // Held low until the first clock after reset release.
    assign ready_o  = r_rdy_en && w_adv1;
    assign w_in_hs  = valid_i && ready_o;
    assign w_out_hs = r_s2_v && ready_i;

    always_comb begin
        w_err   = r_s1_lmulti || r_s1_rmulti || (r_s1_lzero != r_s1_rzero) ||
                  (r_s1_lidx < r_s1_ridx);
        w_empty = r_s1_lzero && r_s1_rzero;
        w_span  = '0;
        if (!w_err && !w_empty) begin
            w_span = SPAN_W'(r_s1_lidx) - SPAN_W'(r_s1_ridx) + SPAN_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_rdy_en    <= 1'b0;
            r_s1_v      <= 1'b0;
            r_s1_lidx   <= '0;
            r_s1_ridx   <= '0;
            r_s1_lzero  <= 1'b0;
            r_s1_rzero  <= 1'b0;
            r_s1_lmulti <= 1'b0;
            r_s1_rmulti <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_adv1) begin
                r_s1_v <= w_in_hs;
                if (w_in_hs) begin
                    r_s1_lidx   <= w_lidx;
                    r_s1_ridx   <= w_ridx;
                    r_s1_lzero  <= (left_oh_i == '0);
                    r_s1_rzero  <= (right_oh_i == '0);
                    r_s1_lmulti <= w_lmulti;
                    r_s1_rmulti <= w_rmulti;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_s2_v     <= 1'b0;
            r_s2_lidx  <= '0;
            r_s2_ridx  <= '0;
            r_s2_span  <= '0;
            r_s2_empty <= 1'b0;
            r_s2_err   <= 1'b0;
        end else if (w_adv2) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_s2_lidx  <= w_err ? '0 : r_s1_lidx;
                r_s2_ridx  <= w_err ? '0 : r_s1_ridx;
                r_s2_span  <= w_span;
                r_s2_empty <= w_empty;
                r_s2_err   <= w_err;
            end
        end
    end

    // Clear takes priority over a coinciding delivery.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_max_span <= '0;
            r_word_cnt <= '0;
        end else if (clr_i) begin
            r_max_span <= '0;
            r_word_cnt <= '0;
        end else if (w_out_hs) begin
            if (r_word_cnt != {CNT_W{1'b1}}) begin
                r_word_cnt <= r_word_cnt + CNT_W'(1);
            end
            if (!r_s2_err && (r_s2_span > r_max_span)) begin
                r_max_span <= r_s2_span;
            end
        end
    end

    assign valid_o     = r_s2_v;
    assign left_idx_o  = r_s2_lidx;
    assign right_idx_o = r_s2_ridx;
    assign span_o      = r_s2_span;
    assign empty_o     = r_s2_empty;
    assign err_o       = r_s2_err;
    assign max_span_o  = r_max_span;
    assign word_cnt_o  = r_word_cnt;

endmodule
